reg_file_sb: RTL and testbench

Parametrised multi-port register file with an integrated program-counter register and a per-register pending-write scoreboard. It is the next-generation general-purpose register store for the pipelined core. It sits between decode (reads and busy checks), issue (marks destinations pending) and writeback (commits results and clears pending). The PC register is updated every cycle by the fetch stage without consuming the writeback port.

---
 rtl/reg_file_pkg.sv | 30 +++
 rtl/reg_file_rdport.sv | 40 ++++
 rtl/reg_file_sb.sv | 120 ++++++++++++
 tb/tb_reg_file_sb.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and the PC next-value priority encoding for reg_file_sb.
// The optional read bypass is enabled by defining REG_FILE_BYPASS_EN.
package reg_file_pkg;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_DEPTH    = 8;
   localparam int DEF_RESET_PC = 0;

   typedef enum logic [1:0] {
      PC_HOLD = 2'd0,
      PC_INC  = 2'd1,
      PC_LOAD = 2'd2,
      PC_WB   = 2'd3
   } pc_sel_e;

   // Writeback to the PC outranks a fetch load, which outranks auto-increment.
   function automatic pc_sel_e pc_select(input logic wb_hit, input logic load, input logic inc);
      pc_sel_e sel;
      sel = PC_HOLD;
      if (wb_hit) begin
         sel = PC_WB;
      end else if (load) begin
         sel = PC_LOAD;
      end else if (inc) begin
         sel = PC_INC;
      end
      return sel;
   endfunction

endpackage

// File: rtl/reg_file_rdport.sv
// One read port: register/busy mux, with same-cycle writeback forwarding
// when REG_FILE_BYPASS_EN is defined.
module reg_file_rdport
   import reg_file_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0][WIDTH-1:0] regs,
   input  logic [DEPTH-1:0]            busy,
   input  logic [ADDR_W-1:0]           rd_addr,
   input  logic                        wr_en,
   input  logic [ADDR_W-1:0]           wr_addr,
   input  logic [WIDTH-1:0]            wr_data,
   input  logic                        iss_en,
   input  logic [ADDR_W-1:0]           iss_addr,
   output logic [WIDTH-1:0]            rd_data,
   output logic                        rd_busy
);

`ifdef REG_FILE_BYPASS_EN
   // A same-cycle issue to the forwarded register means a newer producer is in flight.
   always_comb begin
      rd_data = regs[rd_addr];
      rd_busy = busy[rd_addr];
      if (wr_en && (wr_addr == rd_addr)) begin
         rd_data = wr_data;
         rd_busy = iss_en && (iss_addr == rd_addr);
      end
   end
`else
   logic unused_bypass;

   assign rd_data       = regs[rd_addr];
   assign rd_busy       = busy[rd_addr];
   assign unused_bypass = ^{wr_en, wr_addr, wr_data, iss_en, iss_addr};
`endif

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with integrated PC register and pending-write scoreboard.
// Define REG_FILE_BYPASS_EN to forward writeback data to the read ports.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int               WIDTH    = DEF_WIDTH,
   parameter int               DEPTH    = DEF_DEPTH,
   parameter int               ADDR_W   = $clog2(DEPTH),
   parameter int               PC_INDEX = DEPTH - 1,
   parameter int               PC_STEP  = 1,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [WIDTH-1:0]  rd_data1,
   output logic [WIDTH-1:0]  rd_data2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic              pc_load,
   input  logic [WIDTH-1:0]  pc_in,
   input  logic              pc_inc,
   output logic [WIDTH-1:0]  pc_out,
   output logic [DEPTH-1:0]  busy_vec
);

   localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_INDEX);

   logic [DEPTH-1:0][WIDTH-1:0] regs;
   logic [DEPTH-1:0]            busy;
   logic [WIDTH-1:0]            pc_next;
   pc_sel_e                     pc_sel;

   always_comb begin
      pc_sel  = pc_select(wr_en && (wr_addr == PC_ADDR), pc_load, pc_inc);
      pc_next = regs[PC_INDEX];
      case (pc_sel)
         PC_WB:   pc_next = wr_data;
         PC_LOAD: pc_next = pc_in;
         PC_INC:  pc_next = regs[PC_INDEX] + WIDTH'(PC_STEP);
         default: pc_next = regs[PC_INDEX];
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_reg
         logic [WIDTH-1:0] data_reg;
         logic             busy_reg;

         if (gi == PC_INDEX) begin : g_pc
            always_ff @(posedge clk or negedge reset) begin
               if (!reset) begin
                  data_reg <= RESET_PC;
               end else begin
                  data_reg <= pc_next;
               end
            end
         end else begin : g_gpr
            always_ff @(posedge clk or negedge reset) begin
               if (!reset) begin
                  data_reg <= '0;
               end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                  data_reg <= wr_data;
               end
            end
         end

         // Issue is checked first so a same-cycle new producer keeps the bit set.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               busy_reg <= 1'b0;
            end else if (iss_en && (iss_addr == ADDR_W'(gi))) begin
               busy_reg <= 1'b1;
            end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
               busy_reg <= 1'b0;
            end
         end

         assign regs[gi] = data_reg;
         assign busy[gi] = busy_reg;
      end
   endgenerate

   assign pc_out   = regs[PC_INDEX];
   assign busy_vec = busy;

   reg_file_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rdport1 (
      .regs     (regs),
      .busy     (busy),
      .rd_addr  (rd_addr1),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .rd_data  (rd_data1),
      .rd_busy  (rd_busy1)
   );

   reg_file_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rdport2 (
      .regs     (regs),
      .busy     (busy),
      .rd_addr  (rd_addr2),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .rd_data  (rd_data2),
      .rd_busy  (rd_busy2)
   );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb with default parameters;
// write-cycle read expectations follow REG_FILE_BYPASS_EN when it is defined.
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  rd_addr1, rd_addr2;
   logic [15:0] rd_data1, rd_data2;
   logic        rd_busy1, rd_busy2;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic        iss_en;
   logic [2:0]  iss_addr;
   logic        pc_load;
   logic [15:0] pc_in;
   logic        pc_inc;
   logic [15:0] pc_out;
   logic [7:0]  busy_vec;

   int tests = 0;
   int fails = 0;

   reg_file_sb dut (
      .clk      (clk),
      .reset    (reset),
      .rd_addr1 (rd_addr1),
      .rd_addr2 (rd_addr2),
      .rd_data1 (rd_data1),
      .rd_data2 (rd_data2),
      .rd_busy1 (rd_busy1),
      .rd_busy2 (rd_busy2),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .pc_load  (pc_load),
      .pc_in    (pc_in),
      .pc_inc   (pc_inc),
      .pc_out   (pc_out),
      .busy_vec (busy_vec)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("[TB] %s observed %h expected %h", tag, obs, exp);
   endtask

   // Advance to just after the next rising edge, then drop all enables.
   task automatic step();
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
      iss_en  = 1'b0;
      pc_load = 1'b0;
      pc_inc  = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      rd_addr1 = 3'd3; rd_addr2 = 3'd0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      iss_en = 1'b0; iss_addr = '0;
      pc_load = 1'b0; pc_in = '0; pc_inc = 1'b0;
      #1;
      check("reset_pc", pc_out, 16'h0000);
      check("reset_busy", {8'h00, busy_vec}, 16'h0000);
      check("reset_r3", rd_data1, 16'h0000);
      @(posedge clk); #1;
      reset = 1'b1;

      // R3 <= 0x1234, PC <= 0x0055, R2 marked pending, then async reset
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
      pc_load = 1'b1; pc_in = 16'h0055;
      iss_en = 1'b1; iss_addr = 3'd2;
      step();
      rd_addr1 = 3'd3;
      #1;
      check("pre_reset_r3", rd_data1, 16'h1234);
      check("pre_reset_pc", pc_out, 16'h0055);
      check("pre_reset_busy", {8'h00, busy_vec}, 16'h0004);
      reset = 1'b0;
      #1;
      check("async_reset_r3", rd_data1, 16'h0000);
      check("async_reset_busy", {8'h00, busy_vec}, 16'h0000);
      check("async_reset_pc", pc_out, 16'h0000);
      #1;
      reset = 1'b1;
      step();

      // Write R2 <= 0xBEEF and read it in and after the write cycle
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hBEEF;
      rd_addr1 = 3'd2;
      #1;
`ifdef REG_FILE_BYPASS_EN
      check("wr_cycle_r2", rd_data1, 16'hBEEF);
`else
      check("wr_cycle_r2", rd_data1, 16'h0000);
`endif
      step();
      #1;
      check("after_wr_r2", rd_data1, 16'hBEEF);

      // Scoreboard on R5
      iss_en = 1'b1; iss_addr = 3'd5; rd_addr2 = 3'd5;
      #1;
      check("iss_cycle_busy5", {15'd0, rd_busy2}, 16'h0000);
      step();
      #1;
      check("after_iss_busy5", {15'd0, rd_busy2}, 16'h0001);
      check("after_iss_vec", {8'h00, busy_vec}, 16'h0020);
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h0003;
      step();
      #1;
      check("after_wb_busy5", {15'd0, rd_busy2}, 16'h0000);
      check("after_wb_r5", rd_data2, 16'h0003);
      iss_en = 1'b1; iss_addr = 3'd5;
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h0007;
      #1;
`ifdef REG_FILE_BYPASS_EN
      check("iss_wb_cycle_busy5", {15'd0, rd_busy2}, 16'h0001);
      check("iss_wb_cycle_r5", rd_data2, 16'h0007);
`else
      check("iss_wb_cycle_busy5", {15'd0, rd_busy2}, 16'h0000);
      check("iss_wb_cycle_r5", rd_data2, 16'h0003);
`endif
      step();
      #1;
      check("iss_wb_busy5", {15'd0, rd_busy2}, 16'h0001);
      check("iss_wb_r5", rd_data2, 16'h0007);

      // PC wrap
      pc_load = 1'b1; pc_in = 16'hFFFF;
      step();
      #1;
      check("pc_load_ffff", pc_out, 16'hFFFF);
      pc_inc = 1'b1;
      step();
      rd_addr1 = 3'd7;
      #1;
      check("pc_wrap", pc_out, 16'h0000);
      check("pc_read_port", rd_data1, 16'h0000);
      pc_inc = 1'b1;
      step();
      #1;
      check("pc_inc_once", pc_out, 16'h0001);

      // PC priority
      wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h0100;
      pc_load = 1'b1; pc_in = 16'h0200; pc_inc = 1'b1;
      step();
      #1;
      check("pc_prio_wb", pc_out, 16'h0100);
      pc_load = 1'b1; pc_in = 16'h0200; pc_inc = 1'b1;
      step();
      #1;
      check("pc_prio_load", pc_out, 16'h0200);
      step();
      #1;
      check("pc_hold", pc_out, 16'h0200);

      // Dual read
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1111;
      step();
      wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444;
      step();
      rd_addr1 = 3'd1; rd_addr2 = 3'd4;
      #1;
      check("dual_rd1_r1", rd_data1, 16'h1111);
      check("dual_rd2_r4", rd_data2, 16'h4444);
      rd_addr1 = 3'd4; rd_addr2 = 3'd1;
      #1;
      check("dual_rd1_r4", rd_data1, 16'h4444);
      check("dual_rd2_r1", rd_data2, 16'h1111);
      rd_addr1 = 3'd3;
      #1;
      check("untouched_r3", rd_data1, 16'h0000);

      // Issue to the PC index sets its busy bit; PC keeps counting
      iss_en = 1'b1; iss_addr = 3'd7; pc_inc = 1'b1;
      step();
      #1;
      check("pc_busy_vec", {8'h00, busy_vec}, 16'h00A0);
      check("pc_after_iss", pc_out, 16'h0201);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
